// File: rtl/store_write_queue_pkg.sv
// rtl/store_write_queue_pkg.sv - shared widths for the store write queue
package store_write_queue_pkg;
  localparam int SWQ_ADR_W     = 16;
  localparam int SWQ_DAT_W     = 8;
  localparam int SWQ_MAX_BYTES = 3;
  localparam int SWQ_CNT_W     = 2;
endpackage

// File: rtl/store_write_queue_wq_entry_match.sv
// rtl/store_write_queue_wq_entry_match.sv - snoop compare against one queued store entry
module wq_entry_match
  import store_write_queue_pkg::*;
#(
  parameter int ADR_WIDTH = SWQ_ADR_W
) (
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [SWQ_CNT_W-1:0] cnt_i,
  input  logic [SWQ_CNT_W-1:0] idx_i,
  input  logic                 vld_i,
  input  logic [ADR_WIDTH-1:0] snp_adr_i,
  output logic                 match_o
);

  // Modular distance from the entry base makes address wrap fall out for free.
  logic [ADR_WIDTH-1:0] ofs;

  assign ofs     = snp_adr_i - adr_i;
  assign match_o = vld_i && (ofs < ADR_WIDTH'(cnt_i)) && (ofs >= ADR_WIDTH'(idx_i));

endmodule

// File: rtl/store_write_queue.sv
// rtl/store_write_queue.sv - multi-byte store FIFO drained as single-byte writes with read hazard snoop
module store_write_queue
  import store_write_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADR_WIDTH = SWQ_ADR_W,
  parameter int DAT_WIDTH = SWQ_DAT_W
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_i,
  input  logic [SWQ_CNT_W-1:0]               cnt_i,
  input  logic [ADR_WIDTH-1:0]               adr_i,
  input  logic [SWQ_MAX_BYTES*DAT_WIDTH-1:0] dat_i,
  input  logic                               drain_en_i,
  input  logic [ADR_WIDTH-1:0]               snp_adr_i,
  output logic                               stl_o,
  output logic                               empty_o,
  output logic                               we_o,
  output logic [ADR_WIDTH-1:0]               w_adr_o,
  output logic [DAT_WIDTH-1:0]               w_dat_o,
  output logic                               hit_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int SDAT_W = SWQ_MAX_BYTES * DAT_WIDTH;

  logic [ADR_WIDTH-1:0] adr_q [DEPTH];
  logic [SDAT_W-1:0]    dat_q [DEPTH];
  logic [SWQ_CNT_W-1:0] cnt_q [DEPTH];

  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [SWQ_CNT_W-1:0] idx_q, idx_d;

  logic push, pop, last_byte;
  logic [DEPTH-1:0] match;

  assign empty_o   = (occ_q == '0);
  assign stl_o     = (occ_q == OCC_W'(DEPTH));
  assign we_o      = !empty_o && drain_en_i;
  assign last_byte = (idx_q == cnt_q[head_q] - SWQ_CNT_W'(1));
  assign push      = req_i && (cnt_i != '0) && !stl_o;
  assign pop       = we_o && last_byte;

  // Outputs are forced to zero while empty so stale storage never leaks out.
  assign w_adr_o = empty_o ? '0 : adr_q[head_q] + ADR_WIDTH'(idx_q);
  assign w_dat_o = empty_o ? '0 : dat_q[head_q][int'(idx_q)*DAT_WIDTH +: DAT_WIDTH];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    idx_d  = idx_q;
    occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (we_o) begin
      if (last_byte) begin
        idx_d  = '0;
        head_d = head_q + PTR_W'(1);
      end else begin
        idx_d = idx_q + SWQ_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      idx_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      idx_q  <= idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      adr_q[tail_q] <= adr_i;
      dat_q[tail_q] <= dat_i;
      cnt_q[tail_q] <= cnt_i;
    end
  end

  // Slot validity comes from its distance behind head; only the head slot has consumed bytes.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PTR_W-1:0]     ofs;
    logic [SWQ_CNT_W-1:0] start;
    logic                 vld;

    assign ofs   = PTR_W'(g) - head_q;
    assign start = (ofs == '0) ? idx_q : '0;
    assign vld   = ({1'b0, ofs} < occ_q);

    wq_entry_match #(
      .ADR_WIDTH(ADR_WIDTH)
    ) u_match (
      .adr_i    (adr_q[g]),
      .cnt_i    (cnt_q[g]),
      .idx_i    (start),
      .vld_i    (vld),
      .snp_adr_i(snp_adr_i),
      .match_o  (match[g])
    );
  end

  assign hit_o = |match;

endmodule

// File: tb/tb_store_write_queue.sv
// tb/tb_store_write_queue.sv - self-checking bench for store_write_queue
module tb_store_write_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, req, drain;
  logic [1:0]  cnt;
  logic [15:0] adr, snp;
  logic [23:0] dat;
  logic        stl_o, empty_o, we_o, hit_o;
  logic [15:0] w_adr_o;
  logic [7:0]  w_dat_o;

  always #5 clk = ~clk;

  store_write_queue #(.DEPTH(DEPTH), .ADR_WIDTH(16), .DAT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .cnt_i(cnt), .adr_i(adr), .dat_i(dat),
    .drain_en_i(drain), .snp_adr_i(snp), .stl_o(stl_o), .empty_o(empty_o),
    .we_o(we_o), .w_adr_o(w_adr_o), .w_dat_o(w_dat_o), .hit_o(hit_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference: flat list of pending bytes in write order plus bytes left per entry.
  typedef struct {logic [15:0] a; logic [7:0] d;} byte_t;
  byte_t pend[$];
  int    ent_rem[$];
  bit    mdl_ok = 0;

  logic [15:0] watch_adr = 16'hFFFF;
  int          watch_cnt = 0;

  typedef struct {
    logic rst; logic req; logic [1:0] cnt; logic [15:0] adr; logic [23:0] dat;
    logic de; logic [15:0] snp;
    logic stl; logic emp; logic we; logic [15:0] wa; logic [7:0] wd; logic hit;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic q, input logic [1:0] c, input logic [15:0] a,
                      input logic [23:0] d, input logic de, input logic [15:0] s);
    logic e_stl, e_emp, e_we, e_hit;
    logic [15:0] e_adr;
    logic [7:0]  e_dat;
    byte_t nb;
    rst = r; req = q; cnt = c; adr = a; dat = d; drain = de; snp = s;
    #1;
    e_emp = (ent_rem.size() == 0);
    e_stl = (ent_rem.size() == DEPTH);
    e_we  = !e_emp && de;
    e_adr = '0;
    e_dat = '0;
    if (!e_emp) begin
      e_adr = pend[0].a;
      e_dat = pend[0].d;
    end
    e_hit = 1'b0;
    foreach (pend[i]) if (pend[i].a == s) e_hit = 1'b1;
    if (mdl_ok) begin
      chk("mdl_stl", 32'(stl_o), 32'(e_stl));
      chk("mdl_empty", 32'(empty_o), 32'(e_emp));
      chk("mdl_we", 32'(we_o), 32'(e_we));
      chk("mdl_w_adr", 32'(w_adr_o), 32'(e_adr));
      chk("mdl_w_dat", 32'(w_dat_o), 32'(e_dat));
      chk("mdl_hit", 32'(hit_o), 32'(e_hit));
    end
    if (we_o === 1'b1 && w_adr_o === watch_adr) watch_cnt++;
    @(posedge clk);
    if (r) begin
      pend.delete();
      ent_rem.delete();
      mdl_ok = 1;
    end else begin
      if (e_we) begin
        void'(pend.pop_front());
        ent_rem[0] = ent_rem[0] - 1;
        if (ent_rem[0] == 0) void'(ent_rem.pop_front());
      end
      if (q && c != 0 && !e_stl) begin
        for (int k = 0; k < int'(c); k++) begin
          nb.a = 16'(a + 16'(k));
          nb.d = d[8*k +: 8];
          pend.push_back(nb);
        end
        ent_rem.push_back(int'(c));
      end
    end
    #1;
  endtask

  initial begin
    tbl[0]  = '{0,0,0,16'h0000,24'h0,     1,16'h0003, 0,1,0,16'h0000,8'h00,0};
    tbl[1]  = '{0,1,1,16'h0003,24'h0000AA,1,16'h0003, 0,1,0,16'h0000,8'h00,0};
    tbl[2]  = '{0,0,0,16'h0000,24'h0,     1,16'h0003, 0,0,1,16'h0003,8'hAA,1};
    tbl[3]  = '{0,0,0,16'h0000,24'h0,     1,16'h0003, 0,1,0,16'h0000,8'h00,0};
    tbl[4]  = '{0,1,3,16'hFFFE,24'h332211,0,16'h0000, 0,1,0,16'h0000,8'h00,0};
    tbl[5]  = '{0,0,0,16'h0000,24'h0,     1,16'h0000, 0,0,1,16'hFFFE,8'h11,1};
    tbl[6]  = '{0,0,0,16'h0000,24'h0,     1,16'h0000, 0,0,1,16'hFFFF,8'h22,1};
    tbl[7]  = '{0,0,0,16'h0000,24'h0,     1,16'h0000, 0,0,1,16'h0000,8'h33,1};
    tbl[8]  = '{0,0,0,16'h0000,24'h0,     1,16'h0000, 0,1,0,16'h0000,8'h00,0};
    tbl[9]  = '{0,1,2,16'h0100,24'h00BBAA,1,16'h0000, 0,1,0,16'h0000,8'h00,0};
    tbl[10] = '{0,1,1,16'h0200,24'h0000CC,0,16'h0101, 0,0,0,16'h0100,8'hAA,1};
    tbl[11] = '{0,0,0,16'h0000,24'h0,     1,16'h0200, 0,0,1,16'h0100,8'hAA,1};
    tbl[12] = '{0,0,0,16'h0000,24'h0,     0,16'h0100, 0,0,0,16'h0101,8'hBB,0};
    tbl[13] = '{0,0,0,16'h0000,24'h0,     1,16'h0100, 0,0,1,16'h0101,8'hBB,0};
    tbl[14] = '{0,0,0,16'h0000,24'h0,     0,16'h0101, 0,0,0,16'h0200,8'hCC,0};
    tbl[15] = '{0,0,0,16'h0000,24'h0,     1,16'h0200, 0,0,1,16'h0200,8'hCC,1};
    tbl[16] = '{0,0,0,16'h0000,24'h0,     1,16'h0200, 0,1,0,16'h0000,8'h00,0};

    rst = 1; req = 0; cnt = 0; adr = 0; dat = 0; drain = 0; snp = 0;
    step(1, 0, 0, 16'h0, 24'h0, 0, 16'h0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; cnt = tbl[i].cnt; adr = tbl[i].adr;
      dat = tbl[i].dat; drain = tbl[i].de; snp = tbl[i].snp;
      #1;
      chk($sformatf("vec%0d_stl", i), 32'(stl_o), 32'(tbl[i].stl));
      chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(tbl[i].emp));
      chk($sformatf("vec%0d_we", i), 32'(we_o), 32'(tbl[i].we));
      chk($sformatf("vec%0d_w_adr", i), 32'(w_adr_o), 32'(tbl[i].wa));
      chk($sformatf("vec%0d_w_dat", i), 32'(w_dat_o), 32'(tbl[i].wd));
      chk($sformatf("vec%0d_hit", i), 32'(hit_o), 32'(tbl[i].hit));
      step(tbl[i].rst, tbl[i].req, tbl[i].cnt, tbl[i].adr, tbl[i].dat, tbl[i].de, tbl[i].snp);
    end

    // Fill while drain is held off, then prove an extra request is dropped.
    watch_adr = 16'h1234; watch_cnt = 0;
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 16'h0010 + 16'(i), 24'(i + 1), 0, 16'h0);
    chk("full_stl", 32'(stl_o), 32'd1);
    step(0, 1, 1, 16'h1234, 24'h77, 0, 16'h1234);
    for (int i = 0; i < DEPTH; i++) begin
      req = 0; drain = 1; #1;
      chk("full_order_we", 32'(we_o), 32'd1);
      chk("full_order_adr", 32'(w_adr_o), 32'(16'h0010 + 16'(i)));
      step(0, 0, 0, 16'h0, 24'h0, 1, 16'h0);
    end
    step(0, 0, 0, 16'h0, 24'h0, 1, 16'h1234);
    chk("never_1234", 32'(watch_cnt), 32'd0);

    // Full queue popping its head on the same edge still rejects the push.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 16'h0020 + 16'(i), 24'h5A, 0, 16'h0);
    watch_adr = 16'h0055; watch_cnt = 0;
    req = 1; cnt = 1; adr = 16'h0055; drain = 1; #1;
    chk("popfull_stl", 32'(stl_o), 32'd1);
    step(0, 1, 1, 16'h0055, 24'h000055, 1, 16'h0);
    chk("popfull_next_stl", 32'(stl_o), 32'd0);
    step(0, 1, 1, 16'h0055, 24'h000055, 1, 16'h0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 16'h0, 24'h0, 1, 16'h0055);
    chk("popfull_once", 32'(watch_cnt), 32'd1);
    chk("popfull_empty", 32'(empty_o), 32'd1);

    // Reset while the second byte of a three-byte entry is on the bus.
    step(0, 1, 3, 16'h0300, 24'hCCBBAA, 0, 16'h0302);
    watch_adr = 16'h0302; watch_cnt = 0;
    step(0, 0, 0, 16'h0, 24'h0, 1, 16'h0302);
    chk("rst_mid_adr", 32'(w_adr_o), 32'h0301);
    step(1, 0, 0, 16'h0, 24'h0, 1, 16'h0302);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_hit", 32'(hit_o), 32'd0);
    chk("rst_w_adr", 32'(w_adr_o), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 24'h0, 1, 16'h0302);
    chk("rst_no_third", 32'(watch_cnt), 32'd0);

    // Randomised traffic near the address wrap, checked against the byte-list model.
    for (int n = 0; n < 3000; n++) begin
      logic        r_r, r_q, r_de;
      logic [1:0]  r_c;
      logic [15:0] r_a, r_s;
      r_r  = ($urandom_range(0, 99) == 0);
      r_q  = ($urandom_range(0, 3) != 0);
      r_c  = 2'($urandom_range(0, 3));
      r_a  = 16'hFFFC + 16'($urandom_range(0, 11));
      r_de = ($urandom_range(0, 2) != 0);
      if (pend.size() != 0 && $urandom_range(0, 1) == 1)
        r_s = pend[$urandom_range(0, pend.size() - 1)].a;
      else
        r_s = 16'hFFFC + 16'($urandom_range(0, 15));
      step(r_r, r_q, r_c, r_a, 24'($urandom), r_de, r_s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
